// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one 32-bit ALU shared round-robin by two valid/ready requesters, one op in flight.
// Optional perf counters (grant_cnt0/1, stall_cnt) are built when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter #(
    parameter int unsigned FIRST_PRIO = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [63:0]       req_a,
    input  logic [63:0]       req_b,
    input  logic [5:0]        req_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [31:0]       rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 4;
    localparam logic RST_LAST_GRANT = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    generate
        if (FIRST_PRIO > 1 || CNT_W == 0) begin : g_param_check
            $error("alu_share_arbiter: FIRST_PRIO must be 0/1 and CNT_W nonzero");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic                r_id;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_rsp_result;
    logic [FLAG_W-1:0]   r_rsp_flags;
    logic                r_rsp_err;

    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_grant_id;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [OP_W-1:0]     w_sel_op;

    logic                w_is_sub;
    logic [DATA_W-1:0]   w_b_eff;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_alu_result;
    logic [FLAG_W-1:0]   w_alu_flags;
    logic                w_alu_c;
    logic                w_alu_v;
    logic                w_alu_err;

    // Round-robin grant, only offered while idle; a tie goes to the requester not served last.
    always_comb begin : p_arb
        w_grant = 2'b00;
        if (r_state == S_IDLE) begin
            if (&req_valid) begin
                w_grant = r_last_grant ? 2'b01 : 2'b10;
            end else begin
                w_grant = req_valid;
            end
        end
    end

    assign w_accept   = |w_grant;
    assign w_grant_id = w_grant[1];
    assign w_sel_a    = w_grant_id ? req_a[63:32] : req_a[31:0];
    assign w_sel_b    = w_grant_id ? req_b[63:32] : req_b[31:0];
    assign w_sel_op   = w_grant_id ? req_op[5:3]  : req_op[2:0];

    // ALU on the latched operands; SUB is a + ~b + 1 so C means "no borrow".
    always_comb begin : p_alu
        w_is_sub     = (r_op == 3'b001);
        w_b_eff      = w_is_sub ? ~r_b : r_b;
        w_sum        = {1'b0, r_a} + {1'b0, w_b_eff} + 33'(w_is_sub);
        w_alu_result = '0;
        w_alu_c      = 1'b0;
        w_alu_v      = 1'b0;
        w_alu_err    = 1'b0;
        case (r_op)
            3'b000, 3'b001: begin
                w_alu_result = w_sum[DATA_W-1:0];
                w_alu_c      = w_sum[DATA_W];
                w_alu_v      = (r_a[31] == w_b_eff[31]) && (w_sum[31] != r_a[31]);
            end
            3'b100:  w_alu_result = r_a & r_b;
            3'b101:  w_alu_result = r_a | r_b;
            3'b110:  w_alu_result = r_a ^ r_b;
            3'b111:  w_alu_result = r_a & ~r_b;
            default: w_alu_err    = 1'b1;
        endcase
        w_alu_flags = w_alu_err ? 4'b0000
                    : {w_alu_result[31], (w_alu_result == '0), w_alu_c, w_alu_v};
    end

    always_ff @(posedge clk) begin : p_state
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : p_next
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (rsp_ready[r_id]) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin : p_out
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: req_ready = w_grant;
            S_EXEC: busy = 1'b1;
            S_RESP: begin
                busy           = 1'b1;
                rsp_valid[r_id] = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture on accept, response capture at the end of EXEC.
    always_ff @(posedge clk) begin : p_data
        if (reset) begin
            r_last_grant <= RST_LAST_GRANT;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_op         <= w_sel_op;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= w_alu_result;
                r_rsp_flags  <= w_alu_flags;
                r_rsp_err    <= w_alu_err;
            end
        end
    end

    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] r_grant_cnt0;
    logic [CNT_W-1:0] r_grant_cnt1;
    logic [CNT_W-1:0] r_stall_cnt;

    // Free-running wrap-around counters: accepts per requester and RESP cycles left waiting.
    always_ff @(posedge clk) begin : p_perf
        if (reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_accept && !w_grant_id) r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
            if (w_accept &&  w_grant_id) r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
            if ((r_state == S_RESP) && !rsp_ready[r_id]) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (FIRST_PRIO=0); perf counters checked when
// ALU_ARB_PERF_EN is defined.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.FIRST_PRIO(0), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .busy       (busy)
`ifdef ALU_ARB_PERF_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .stall_cnt  (stall_cnt)
`endif
    );

    // Operation table: op, a, b, expected result, flags {N,Z,C,V}, err
    logic [2:0]  t_op  [10] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b001,
                                3'b110, 3'b101, 3'b111, 3'b011, 3'b001};
    logic [31:0] t_a   [10] = '{32'd123, 32'hF0F0_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
                                32'hA5A5_A5A5, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd5};
    logic [31:0] t_b   [10] = '{32'd456, 32'hFFFF_0000, 32'd1, 32'd1, 32'd1,
                                32'hA5A5_A5A5, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd1, 32'd7};
    logic [31:0] t_res [10] = '{32'd0, 32'hF0F0_0000, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                32'd0, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFE};
    logic [3:0]  t_flg [10] = '{4'b0000, 4'b1000, 4'b0110, 4'b1000, 4'b0011,
                                4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    logic        t_err [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_valid[ch] = 1'b1;
        if (ch == 0) begin
            req_a[31:0] = a; req_b[31:0] = b; req_op[2:0] = op;
        end else begin
            req_a[63:32] = a; req_b[63:32] = b; req_op[5:3] = op;
        end
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 2'b11;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Drive one op with rsp_ready high; return what the DUT showed at accept and at T+2.
    task automatic do_op(input int ch, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, output logic [1:0] got_ready,
                         output logic [1:0] got_vld, output logic [31:0] res,
                         output logic [3:0] flg, output logic err);
        set_req(ch, a, b, op);
        #1;
        got_ready = req_ready;
        tick;
        req_valid = 2'b00;
        tick;
        got_vld = rsp_valid;
        res     = rsp_result;
        flg     = rsp_flags;
        err     = rsp_err;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", rsp_result); end
        checks++; if (rsp_flags !== 4'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_flags_err: got %b/%b expected 0000/0", rsp_flags, rsp_err); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
`ifdef ALU_ARB_PERF_EN
        checks++; if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0", grant_cnt0, grant_cnt1, stall_cnt); end
`endif
    endtask

    task automatic test_sub_latency;
        set_req(0, 32'd5, 32'd5, 3'b001);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sub_accept_ready: got %b expected 01", req_ready); end
        tick;
        req_valid = 2'b00;
        checks++; if (busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL sub_exec: got busy=%b vld=%b rdy=%b expected 1/00/00", busy, rsp_valid, req_ready); end
        tick;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sub_rsp_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_result !== 32'd0 || rsp_flags !== 4'b0110 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL sub_rsp: got %h/%b/%b expected 00000000/0110/0", rsp_result, rsp_flags, rsp_err); end
        tick;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL sub_release: got vld=%b busy=%b expected 00/0", rsp_valid, busy); end
    endtask

    task automatic test_add_ch1;
        set_req(1, 32'h7FFF_FFFF, 32'd1, 3'b000);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL add1_ready: got %b expected 10", req_ready); end
        tick;
        req_valid = 2'b00;
        tick;
        rsp_ready = 2'b01;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL add1_rsp_valid: got %b expected 10", rsp_valid); end
        checks++; if (rsp_result !== 32'h8000_0000 || rsp_flags !== 4'b1001 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL add1_rsp: got %h/%b/%b expected 80000000/1001/0", rsp_result, rsp_flags, rsp_err); end
        tick;
        checks++; if (rsp_valid !== 2'b10 || busy !== 1'b1) begin
            errors++; $display("FAIL add1_other_ready_ignored: got vld=%b busy=%b expected 10/1", rsp_valid, busy); end
        rsp_ready = 2'b10;
        tick;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL add1_release: got vld=%b busy=%b expected 00/0", rsp_valid, busy); end
        rsp_ready = 2'b11;
    endtask

    task automatic test_alu_ops;
        logic [1:0]  g_rdy;
        logic [1:0]  g_vld;
        logic [31:0] g_res;
        logic [3:0]  g_flg;
        logic        g_err;
        for (int i = 0; i < 10; i++) begin
            do_op(0, t_a[i], t_b[i], t_op[i], g_rdy, g_vld, g_res, g_flg, g_err);
            checks++; if (g_rdy !== 2'b01 || g_vld !== 2'b01) begin
                errors++; $display("FAIL op%0d_handshake: got rdy=%b vld=%b expected 01/01", i, g_rdy, g_vld); end
            checks++; if (g_res !== t_res[i] || g_flg !== t_flg[i] || g_err !== t_err[i]) begin
                errors++; $display("FAIL op%0d_result: got %h/%b/%b expected %h/%b/%b",
                                   i, g_res, g_flg, g_err, t_res[i], t_flg[i], t_err[i]); end
        end
    endtask

    task automatic test_round_robin;
        logic exp_id;
        do_reset;
        set_req(0, 32'd10, 32'd3, 3'b000);
        set_req(1, 32'd10, 32'd3, 3'b001);
        #1;
        exp_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr%0d_grant: got %b expected %b", i, req_ready, exp_id ? 2'b10 : 2'b01); end
            tick;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr%0d_exec_ready: got %b expected 00", i, req_ready); end
            tick;
            checks++; if (rsp_valid !== (exp_id ? 2'b10 : 2'b01) || rsp_result !== (exp_id ? 32'd7 : 32'd13)) begin
                errors++; $display("FAIL rr%0d_rsp: got vld=%b res=%0d expected %b/%0d", i, rsp_valid, rsp_result,
                                   exp_id ? 2'b10 : 2'b01, exp_id ? 7 : 13); end
            tick;
            exp_id = ~exp_id;
        end
        req_valid = 2'b00;
`ifdef ALU_ARB_PERF_EN
        checks++; if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd2) begin
            errors++; $display("FAIL rr_grant_cnt: got %0d/%0d expected 2/2", grant_cnt0, grant_cnt1); end
`endif
    endtask

    task automatic test_stall;
`ifdef ALU_ARB_PERF_EN
        logic [15:0] stall0;
`endif
        set_req(0, 32'd3, 32'd4, 3'b000);
        #1;
        tick;
        req_valid = 2'b00;
        tick;
        rsp_ready = 2'b10;
        set_req(0, 32'd1, 32'd1, 3'b000);
        set_req(1, 32'd2, 32'd2, 3'b000);
        #1;
`ifdef ALU_ARB_PERF_EN
        stall0 = stall_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd7 || rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin
                errors++; $display("FAIL stall%0d_hold: got vld=%b %h/%b/%b expected 01 00000007/0000/0",
                                   i, rsp_valid, rsp_result, rsp_flags, rsp_err); end
            checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++; $display("FAIL stall%0d_ready_busy: got %b/%b expected 00/1", i, req_ready, busy); end
            tick;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        #1;
`ifdef ALU_ARB_PERF_EN
        checks++; if (stall_cnt !== 16'(stall0 + 16'd4)) begin
            errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, stall0 + 16'd4); end
`endif
        tick;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_release: got vld=%b busy=%b expected 00/0", rsp_valid, busy); end
        rsp_ready = 2'b11;
    endtask

    task automatic test_reset_mid;
        set_req(1, 32'd1, 32'd1, 3'b000);
        #1;
        tick;
        req_valid = 2'b00;
        reset     = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL midrst_idle: got busy=%b vld=%b expected 0/00", busy, rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 2'b00 || rsp_result !== 32'd0) begin
            errors++; $display("FAIL midrst_no_rsp: got vld=%b res=%h expected 00/0", rsp_valid, rsp_result); end
        set_req(0, 32'd8, 32'd2, 3'b001);
        set_req(1, 32'd8, 32'd2, 3'b000);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_prio: got %b expected 01", req_ready); end
        tick;
        req_valid = 2'b00;
        tick;
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd6) begin
            errors++; $display("FAIL midrst_rsp: got vld=%b res=%0d expected 01/6", rsp_valid, rsp_result); end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_sub_latency;
        test_add_ch1;
        test_alu_ops;
        test_round_robin;
        test_stall;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
